// File: rtl/regfile_wb_if.sv
// W-stage write-back and decode read bus for the Y86-64 register file.
// slave is the register file; master is the pipeline side driving it.
interface regfile_wb_if;
  logic        W_en_i;
  logic [3:0]  W_dstE_i;
  logic [63:0] W_valE_i;
  logic [3:0]  W_dstM_i;
  logic [63:0] W_valM_i;
  logic [3:0]  d_srcA_i;
  logic [3:0]  d_srcB_i;
  logic [63:0] d_rvalA_o;
  logic [63:0] d_rvalB_o;
  logic [31:0] wb_cnt_o;

  modport slave (
    input  W_en_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i, d_srcA_i, d_srcB_i,
    output d_rvalA_o, d_rvalB_o, wb_cnt_o
  );

  modport master (
    output W_en_i, W_dstE_i, W_valE_i, W_dstM_i, W_valM_i, d_srcA_i, d_srcB_i,
    input  d_rvalA_o, d_rvalB_o, wb_cnt_o
  );
endinterface

// File: rtl/regfile_wb.sv
// Y86-64 register file: two W-stage write ports, two combinational decode reads, commit counter.
// Define REGFILE_BYPASS_EN to add same-cycle write-through on both read ports.
module regfile_wb #(
  parameter int unsigned NREG  = 15,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input logic         clk_i,
  input logic         rst_n_i,
  regfile_wb_if.slave wb
);

  logic [63:0] regs [NREG];
  logic [31:0] cnt_q;
  logic        we_e;
  logic        we_m;
  logic [1:0]  nwr;
  logic [63:0] rd_a;
  logic [63:0] rd_b;

  // Port M wins a same-register collision, so E is suppressed and it counts once.
  always_comb begin
    we_m = wb.W_en_i && (wb.W_dstM_i != RNONE);
    we_e = wb.W_en_i && (wb.W_dstE_i != RNONE) && !(we_m && (wb.W_dstE_i == wb.W_dstM_i));
    nwr  = {1'b0, we_e} + {1'b0, we_m};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (we_m && (wb.W_dstM_i == 4'(i))) begin
          regs[i] <= wb.W_valM_i;
        end else if (we_e && (wb.W_dstE_i == 4'(i))) begin
          regs[i] <= wb.W_valE_i;
        end
      end
      cnt_q <= cnt_q + 32'(nwr);
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if ((wb.d_srcA_i == 4'(i)) && (wb.d_srcA_i != RNONE)) rd_a = regs[i];
      if ((wb.d_srcB_i == 4'(i)) && (wb.d_srcB_i != RNONE)) rd_b = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wb.W_en_i && (wb.W_dstM_i != RNONE) && (wb.d_srcA_i == wb.W_dstM_i)) begin
      rd_a = wb.W_valM_i;
    end else if (wb.W_en_i && (wb.W_dstE_i != RNONE) && (wb.d_srcA_i == wb.W_dstE_i)) begin
      rd_a = wb.W_valE_i;
    end
    if (wb.W_en_i && (wb.W_dstM_i != RNONE) && (wb.d_srcB_i == wb.W_dstM_i)) begin
      rd_b = wb.W_valM_i;
    end else if (wb.W_en_i && (wb.W_dstE_i != RNONE) && (wb.d_srcB_i == wb.W_dstE_i)) begin
      rd_b = wb.W_valE_i;
    end
`endif
  end

  assign wb.d_rvalA_o = rd_a;
  assign wb.d_rvalB_o = rd_b;
  assign wb.wb_cnt_o  = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb (default or REGFILE_BYPASS_EN build).
module tb_regfile_wb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass = 0;
  int   total = 0;

  regfile_wb_if bus ();

  regfile_wb #(.NREG(15), .RNONE(4'hF)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .wb      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    bus.W_en_i   = en;
    bus.W_dstE_i = de;
    bus.W_valE_i = ve;
    bus.W_dstM_i = dm;
    bus.W_valM_i = vm;
  endtask

  task automatic rd(input logic [3:0] src, output logic [63:0] a, output logic [63:0] b);
    bus.d_srcA_i = src;
    bus.d_srcB_i = src;
    #1;
    a = bus.d_rvalA_o;
    b = bus.d_rvalB_o;
  endtask

  task automatic test_reset();
    logic [63:0] a, b;
    drive(1'b1, 4'h3, 64'h99, 4'h8, 64'h98);
    tick();
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), a, b);
      total++;
      if (a !== 64'h0) $display("FAIL reset_rdA src=%0h: got %h want 0", s, a); else pass++;
      total++;
      if (b !== 64'h0) $display("FAIL reset_rdB src=%0h: got %h want 0", s, b); else pass++;
    end
    total++;
    if (bus.wb_cnt_o !== 32'h0) $display("FAIL reset_cnt: got %h want 0", bus.wb_cnt_o); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 4'hF, 64'h55, 4'hF, 64'h55);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), a, b);
      total++;
      if (a !== 64'h0 || b !== 64'h0)
        $display("FAIL rnone_write src=%0h: got %h/%h want 0/0", s, a, b);
      else pass++;
    end
    total++;
    if (bus.wb_cnt_o !== 32'h0) $display("FAIL rnone_cnt: got %h want 0", bus.wb_cnt_o); else pass++;
  endtask

  task automatic test_dual_write();
    logic [63:0] a, b;
    tick();
    drive(1'b1, 4'h3, 64'h1111, 4'h7, 64'h2222);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    rd(4'h3, a, b);
    total++;
    if (a !== 64'h1111 || b !== 64'h1111) $display("FAIL dual_reg3: got %h/%h want 1111", a, b); else pass++;
    rd(4'h7, a, b);
    total++;
    if (a !== 64'h2222 || b !== 64'h2222) $display("FAIL dual_reg7: got %h/%h want 2222", a, b); else pass++;
    total++;
    if (bus.wb_cnt_o !== 32'd2) $display("FAIL dual_cnt: got %0d want 2", bus.wb_cnt_o); else pass++;
  endtask

  task automatic test_collision();
    logic [63:0] a, b;
    tick();
    drive(1'b1, 4'h4, 64'h100, 4'h4, 64'hDEAD);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    rd(4'h4, a, b);
    total++;
    if (a !== 64'hDEAD) $display("FAIL collision_reg4: got %h want dead", a); else pass++;
    total++;
    if (bus.wb_cnt_o !== 32'd3) $display("FAIL collision_cnt: got %0d want 3", bus.wb_cnt_o); else pass++;
  endtask

  task automatic test_write_gating();
    logic [63:0] a, b;
    tick();
    drive(1'b0, 4'h1, 64'hFFFF, 4'h3, 64'hEEEE);
    tick();
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    rd(4'h1, a, b);
    total++;
    if (a !== 64'h0) $display("FAIL gating_reg1: got %h want 0", a); else pass++;
    rd(4'h3, a, b);
    total++;
    if (b !== 64'h1111) $display("FAIL gating_reg3: got %h want 1111", b); else pass++;
    total++;
    if (bus.wb_cnt_o !== 32'd3) $display("FAIL gating_cnt: got %0d want 3", bus.wb_cnt_o); else pass++;
  endtask

  task automatic test_same_cycle();
    logic [63:0] exp_a, exp_b;
    tick();
    drive(1'b1, 4'h2, 64'hA, 4'hF, 64'h0);
    tick();
    // reg2 now 0xA; write 0xB to it (E) and 0xC to reg9 (M) while reading both
    drive(1'b1, 4'h2, 64'hB, 4'h9, 64'hC);
    bus.d_srcA_i = 4'h2;
    bus.d_srcB_i = 4'h9;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_a = 64'hB;
    exp_b = 64'hC;
`else
    exp_a = 64'hA;
    exp_b = 64'h0;
`endif
    total++;
    if (bus.d_rvalA_o !== exp_a) $display("FAIL same_cycle_A: got %h want %h", bus.d_rvalA_o, exp_a); else pass++;
    total++;
    if (bus.d_rvalB_o !== exp_b) $display("FAIL same_cycle_B: got %h want %h", bus.d_rvalB_o, exp_b); else pass++;
    @(posedge clk);
    #1;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    #1;
    total++;
    if (bus.d_rvalA_o !== 64'hB) $display("FAIL next_cycle_A: got %h want b", bus.d_rvalA_o); else pass++;
    total++;
    if (bus.d_rvalB_o !== 64'hC) $display("FAIL next_cycle_B: got %h want c", bus.d_rvalB_o); else pass++;
    total++;
    if (bus.wb_cnt_o !== 32'd6) $display("FAIL same_cycle_cnt: got %0d want 6", bus.wb_cnt_o); else pass++;
    // M-over-E priority on the read path for a same-register pair
    drive(1'b1, 4'h2, 64'h5E, 4'h2, 64'h5F);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_a = 64'h5F;
`else
    exp_a = 64'hB;
`endif
    total++;
    if (bus.d_rvalA_o !== exp_a) $display("FAIL byp_priority: got %h want %h", bus.d_rvalA_o, exp_a); else pass++;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
  endtask

  task automatic test_async_reset();
    logic [63:0] a, b;
    tick();
    drive(1'b1, 4'h5, 64'h77, 4'hF, 64'h0);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    rd(4'h5, a, b);
    total++;
    if (a !== 64'h77) $display("FAIL pre_reset_reg5: got %h want 77", a); else pass++;
    #1;
    rst_n = 1'b0;
    drive(1'b1, 4'h6, 64'h66, 4'hF, 64'h0);
    rd(4'h5, a, b);
    total++;
    if (a !== 64'h0 || b !== 64'h0) $display("FAIL async_reg5: got %h/%h want 0", a, b); else pass++;
    total++;
    if (bus.wb_cnt_o !== 32'h0) $display("FAIL async_cnt: got %h want 0", bus.wb_cnt_o); else pass++;
    rd(4'h3, a, b);
    total++;
    if (a !== 64'h0) $display("FAIL async_reg3: got %h want 0", a); else pass++;
    @(posedge clk);
    #1;
    rd(4'h6, a, b);
    total++;
    if (a !== 64'h0) $display("FAIL reset_write_lost: got %h want 0", a); else pass++;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_counter_wrap();
    logic [63:0] a, b;
    tick();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    total++;
    if (bus.wb_cnt_o !== 32'hFFFF_FFFF) $display("FAIL preload_cnt: got %h want ffffffff", bus.wb_cnt_o); else pass++;
    drive(1'b1, 4'h1, 64'h5, 4'hF, 64'h0);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    total++;
    if (bus.wb_cnt_o !== 32'h0) $display("FAIL wrap_cnt: got %h want 0", bus.wb_cnt_o); else pass++;
    rd(4'h1, a, b);
    total++;
    if (a !== 64'h5) $display("FAIL wrap_reg1: got %h want 5", a); else pass++;
    drive(1'b1, 4'hE, 64'hE0, 4'h0, 64'h00F);
    tick();
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    total++;
    if (bus.wb_cnt_o !== 32'd2) $display("FAIL post_wrap_cnt: got %0d want 2", bus.wb_cnt_o); else pass++;
    rd(4'hE, a, b);
    total++;
    if (b !== 64'hE0) $display("FAIL reg14: got %h want e0", b); else pass++;
    rd(4'h0, a, b);
    total++;
    if (a !== 64'hF) $display("FAIL reg0: got %h want f", a); else pass++;
  endtask

  initial begin
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    bus.d_srcA_i = 4'hF;
    bus.d_srcB_i = 4'hF;
    test_reset();
    test_dual_write();
    test_collision();
    test_write_gating();
    test_same_cycle();
    test_async_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule
